// File: rtl/simd_product_accumulator.sv
// simd_product_accumulator
// Receive side of the split-carry SIMD multiplier. Each accepted beat is
// decoded into per-lane products for its mode, and those products are summed
// over a group that ends with `last`. The finished sums are held on a
// registered valid/ready output port.
//
// Ports
//   clk, reset          clock; synchronous active-low reset
//   in_valid/in_ready   input beat handshake
//   result_0/result_1   partial-sum vectors from the multiplier
//   result_SIMD_carry   carry bits at the lane boundaries
//   mode, signed_op     decode controls (00 16x16, 01 2x8x8, 10 4x4x4, 11 reserved)
//   last                marks the final beat of a group
//   out_valid/out_ready result handshake
//   acc_0..acc_3        lane sums
//   out_mode            mode of the group
//   out_count           number of beats summed (saturates at all-ones)
//   err_mode            sticky flag: a beat was dropped for a mode conflict or reserved mode
module simd_product_accumulator #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      result_0,
  input  logic [31:0]      result_1,
  input  logic [3:0]       result_SIMD_carry,
  input  logic [1:0]       mode,
  input  logic             signed_op,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_0,
  output logic [ACC_W-1:0] acc_1,
  output logic [ACC_W-1:0] acc_2,
  output logic [ACC_W-1:0] acc_3,
  output logic [1:0]       out_mode,
  output logic [CNT_W-1:0] out_count,
  output logic             err_mode
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [3:0][ACC_W-1:0]       acc_q, acc_d;
  logic [1:0]                  mode_q, mode_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        err_q, err_d;
  logic [3:0][ACC_W-1:0]       lane;
  logic                        beat;

  // ---------------- beat decode ----------------
  // The term built from the carry bit plus the result_1 field is extended by
  // signed_op; the result_0 field is always unsigned. The lane sum is then
  // extended the same way up to ACC_W.
  always_comb begin
    logic [31:0] s32;
    logic [16:0] t17;
    logic [17:0] t18, s18;
    logic [8:0]  t9;
    logic [9:0]  t10, s10;
    s32  = '0;
    t17  = '0;
    t18  = '0;
    s18  = '0;
    t9   = '0;
    t10  = '0;
    s10  = '0;
    lane = '0;
    case (mode)
      2'b00: begin
        s32     = result_0 + result_1;
        lane[0] = {{(ACC_W-32){signed_op & s32[31]}}, s32};
      end
      2'b01: begin
        for (int k = 0; k < 2; k++) begin
          t17     = {result_SIMD_carry[2*k+1], result_1[16*k +: 16]};
          t18     = {signed_op & t17[16], t17};
          s18     = {2'b00, result_0[16*k +: 16]} + t18;
          lane[k] = {{(ACC_W-18){signed_op & s18[17]}}, s18};
        end
      end
      2'b10: begin
        for (int k = 0; k < 4; k++) begin
          t9      = {result_SIMD_carry[k], result_1[8*k +: 8]};
          t10     = {signed_op & t9[8], t9};
          s10     = {2'b00, result_0[8*k +: 8]} + t10;
          lane[k] = {{(ACC_W-10){signed_op & s10[9]}}, s10};
        end
      end
      default: lane = '0;
    endcase
  end

  // ---------------- control ----------------
  assign in_ready  = (state_q != S_DONE) | out_ready;
  assign beat      = in_valid & in_ready;
  assign out_valid = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE && out_ready) state_d = S_IDLE;
        // In DONE, a beat can only arrive together with out_ready, so it
        // always opens a fresh group and never adds to the sums just handed off.
        if (beat) begin
          if (mode == 2'b11) begin
            err_d = 1'b1;
          end else begin
            acc_d   = lane;
            mode_d  = mode;
            cnt_d   = CNT_W'(1);
            state_d = last ? S_DONE : S_ACC;
          end
        end
      end
      S_ACC: begin
        if (beat) begin
          // mode_q is never 11 here, so a reserved-mode beat also counts as a mismatch.
          if (mode == mode_q) begin
            for (int k = 0; k < 4; k++) acc_d[k] = acc_q[k] + lane[k];
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
          if (last) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mode_q  <= 2'b00;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign acc_0     = acc_q[0];
  assign acc_1     = acc_q[1];
  assign acc_2     = acc_q[2];
  assign acc_3     = acc_q[3];
  assign out_mode  = mode_q;
  assign out_count = cnt_q;
  assign err_mode  = err_q;

endmodule

// File: tb/tb_simd_product_accumulator.sv
module tb_simd_product_accumulator;
  localparam int ACC_W = 40;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [31:0]      result_0, result_1;
  logic [3:0]       result_SIMD_carry;
  logic [1:0]       mode;
  logic             signed_op, last;
  logic             out_valid, out_ready;
  logic [ACC_W-1:0] acc_0, acc_1, acc_2, acc_3;
  logic [1:0]       out_mode;
  logic [CNT_W-1:0] out_count;
  logic             err_mode;

  int nvec = 0;
  int nfail = 0;

  simd_product_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .result_0(result_0), .result_1(result_1),
    .result_SIMD_carry(result_SIMD_carry),
    .mode(mode), .signed_op(signed_op), .last(last),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_0(acc_0), .acc_1(acc_1), .acc_2(acc_2), .acc_3(acc_3),
    .out_mode(out_mode), .out_count(out_count), .err_mode(err_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       mode;
    logic             sgn;
    logic [31:0]      r0;
    logic [31:0]      r1;
    logic [3:0]       carry;
    int               nbeats;
    logic [ACC_W-1:0] e0, e1, e2, e3;
    logic [CNT_W-1:0] ecnt;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] c, input logic l);
    in_valid = 1'b1; mode = m; signed_op = s;
    result_0 = a; result_1 = b; result_SIMD_carry = c; last = l;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; last = 1'b0;
  endtask

  // Hand the finished result to the consumer and confirm DONE is left.
  task automatic drain(input string nm);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, ".drained"}, 64'(out_valid), 64'd0);
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, ".in_ready"},  64'(in_ready),  64'd1);
    chk({nm, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({nm, ".acc_0"},     64'(acc_0),     64'd0);
    chk({nm, ".acc_3"},     64'(acc_3),     64'd0);
    chk({nm, ".out_mode"},  64'(out_mode),  64'd0);
    chk({nm, ".out_count"}, 64'(out_count), 64'd0);
    chk({nm, ".err_mode"},  64'(err_mode),  64'd0);
  endtask

  initial begin
    tbl[0] = '{2'b00, 1'b0, 32'h0000FFFF, 32'h00000001, 4'b0000, 1,
               40'h10000, 40'h0, 40'h0, 40'h0, 8'd1};
    tbl[1] = '{2'b01, 1'b1, 32'h00000000, 32'h0000FFFF, 4'b0010, 2,
               40'hFF_FFFF_FFFE, 40'h0, 40'h0, 40'h0, 8'd2};
    tbl[2] = '{2'b10, 1'b0, 32'h01010101, 32'h01010101, 4'b0001, 3,
               40'h306, 40'h6, 40'h6, 40'h6, 8'd3};
    tbl[3] = '{2'b00, 1'b1, 32'h80000000, 32'h00000000, 4'b0000, 1,
               40'hFF_8000_0000, 40'h0, 40'h0, 40'h0, 8'd1};
    tbl[4] = '{2'b00, 1'b0, 32'hFFFFFFFF, 32'h00000002, 4'b0000, 1,
               40'h1, 40'h0, 40'h0, 40'h0, 8'd1};
    tbl[5] = '{2'b10, 1'b1, 32'h00000002, 32'hFF0000FF, 4'b1001, 1,
               40'h1, 40'h0, 40'h0, 40'hFF_FFFF_FFFF, 8'd1};
    tbl[6] = '{2'b01, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1010, 2,
               40'h5FFFC, 40'h5FFFC, 40'h0, 40'h0, 8'd2};
    tbl[7] = '{2'b10, 1'b1, 32'h7F7F7F7F, 32'h01020304, 4'b0000, 1,
               40'h83, 40'h82, 40'h81, 40'h80, 8'd1};

    reset = 1'b0; out_ready = 1'b0;
    idle_in();
    mode = 2'b00; signed_op = 1'b0; result_0 = '0; result_1 = '0; result_SIMD_carry = '0;
    tick(); tick();
    reset = 1'b1;
    tick();
    check_reset_state("reset");

    // Table of groups: each record is one beat repeated nbeats times.
    for (int v = 0; v < 8; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      for (int b = 0; b < tbl[v].nbeats; b++) begin
        chk({nm, ".in_ready"}, 64'(in_ready), 64'd1);
        drive(tbl[v].mode, tbl[v].sgn, tbl[v].r0, tbl[v].r1, tbl[v].carry,
              b == tbl[v].nbeats - 1);
        tick();
      end
      idle_in();
      chk({nm, ".out_valid"}, 64'(out_valid), 64'd1);
      chk({nm, ".acc_0"},     64'(acc_0),     64'(tbl[v].e0));
      chk({nm, ".acc_1"},     64'(acc_1),     64'(tbl[v].e1));
      chk({nm, ".acc_2"},     64'(acc_2),     64'(tbl[v].e2));
      chk({nm, ".acc_3"},     64'(acc_3),     64'(tbl[v].e3));
      chk({nm, ".out_count"}, 64'(out_count), 64'(tbl[v].ecnt));
      chk({nm, ".out_mode"},  64'(out_mode),  64'(tbl[v].mode));
      chk({nm, ".err_mode"},  64'(err_mode),  64'd0);
      drain(nm);
    end

    // Count saturation: 300 beats, sums keep growing, count stops at 255.
    for (int b = 0; b < 300; b++) begin
      drive(2'b10, 1'b0, 32'h01010101, 32'h0, 4'b0000, b == 299);
      tick();
    end
    idle_in();
    chk("sat.acc_0",     64'(acc_0),     64'd300);
    chk("sat.acc_2",     64'(acc_2),     64'd300);
    chk("sat.out_count", 64'(out_count), 64'd255);
    drain("sat");

    // Backpressure, then a new beat accepted in the same cycle as the handoff.
    drive(2'b00, 1'b0, 32'd5, 32'd0, 4'b0000, 1'b1);
    tick();
    drive(2'b00, 1'b0, 32'd7, 32'd1, 4'b0000, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp%0d.in_ready", c),  64'(in_ready),  64'd0);
      chk($sformatf("bp%0d.out_valid", c), 64'(out_valid), 64'd1);
      chk($sformatf("bp%0d.acc_0", c),     64'(acc_0),     64'd5);
      chk($sformatf("bp%0d.out_count", c), 64'(out_count), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_on_release", 64'(in_ready), 64'd1);
    tick();
    out_ready = 1'b0;
    idle_in();
    chk("bp.new_valid", 64'(out_valid), 64'd1);
    chk("bp.new_acc_0", 64'(acc_0),     64'd8);
    chk("bp.new_count", 64'(out_count), 64'd1);
    drain("bp");

    // Mode mismatch drops the second beat but still closes the group.
    drive(2'b01, 1'b0, 32'd5, 32'd0, 4'b0000, 1'b0);
    tick();
    drive(2'b10, 1'b0, 32'h11, 32'd0, 4'b0000, 1'b1);
    tick();
    idle_in();
    chk("mm.out_valid", 64'(out_valid), 64'd1);
    chk("mm.acc_0",     64'(acc_0),     64'd5);
    chk("mm.out_count", 64'(out_count), 64'd1);
    chk("mm.out_mode",  64'(out_mode),  64'd1);
    chk("mm.err_mode",  64'(err_mode),  64'd1);
    drain("mm");
    drive(2'b00, 1'b0, 32'd4, 32'd4, 4'b0000, 1'b1);
    tick();
    idle_in();
    chk("mm.next_acc_0", 64'(acc_0),    64'd8);
    chk("mm.err_sticky", 64'(err_mode), 64'd1);
    drain("mm2");

    // Reset mid-group discards partial sums and the error flag.
    drive(2'b00, 1'b0, 32'd3, 32'd0, 4'b0000, 1'b0);
    tick(); tick();
    idle_in();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_reset_state("rstmid");
    drive(2'b00, 1'b0, 32'd9, 32'd0, 4'b0000, 1'b1);
    tick();
    idle_in();
    chk("rstmid.acc_0", 64'(acc_0),     64'd9);
    chk("rstmid.count", 64'(out_count), 64'd1);
    drain("rstmid");

    // Reserved mode from IDLE: beat swallowed, no result, error raised.
    drive(2'b11, 1'b0, 32'd1, 32'd1, 4'b0000, 1'b1);
    tick();
    idle_in();
    chk("m11.out_valid", 64'(out_valid), 64'd0);
    chk("m11.err_mode",  64'(err_mode),  64'd1);
    chk("m11.in_ready",  64'(in_ready),  64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/simd_product_accumulator.md
# simd_product_accumulator

Receive-side companion to the split-carry SIMD multiplier. Consumes its packed output (two partial-sum vectors plus per-lane carry bits) under a valid/ready handshake. Reconstructs the per-lane products for the active mode and accumulates them over a group of beats terminated by `last`. Presents the finished lane sums on a registered valid/ready output port. Sits between the multiplier and the dot-product/post-processing stage.

## Interface
- `ACC_W`, 40: accumulator width per lane.
- `CNT_W`, 8: width of the beat counter.

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-low; `reset==0` at a rising edge resets the block.
- `in_valid` input 1: an input beat is present.
- `in_ready` output 1: block accepts the beat this cycle.
- `result_0` input 32: partial vector 0 from the multiplier.
- `result_1` input 32: partial vector 1 from the multiplier.
- `result_SIMD_carry` input 4: lane-boundary carry bits.
- `mode` input 2: 00 = 16x16, 01 = sum 8x8, 10 = sum 4x4, 11 = reserved.
- `signed_op` input 1: `a_sign|b_sign` of the producing multiply.
- `last` input 1: final beat of the group.
- `out_valid` output 1: accumulated group result is available.
- `out_ready` input 1: consumer takes the result.
- `acc_0`..`acc_3` output `ACC_W` each: lane sums.
- `out_mode` output 2: mode of the group.
- `out_count` output `CNT_W`: number of beats accumulated.
- `err_mode` output 1: sticky error flag.

## Operation
- **Handshake.** A beat transfers when `in_valid & in_ready`. The result transfers when `out_valid & out_ready`.
- **Decode** (combinational, per beat). Term T is sign-extended when `signed_op=1`, zero-extended otherwise. The lane sum is extended the same way to `ACC_W`.
  - mode 00: lane0 = (`result_0 + result_1`) mod 2^32, treated as a 32-bit value. Lanes 1–3 = 0.
  - mode 01, k=0..1, field [16k+15:16k]:
    - T = {`result_SIMD_carry[2k+1]`, `result_1` field} (17 bit).
    - lane k = zero-extended `result_0` field + T, computed at 18 bits.
    - Lanes 2–3 = 0.
  - mode 10, k=0..3, field [8k+7:8k]:
    - T = {`result_SIMD_carry[k]`, `result_1` field} (9 bit).
    - lane k = zero-extended `result_0` field + T, computed at 10 bits.
  - mode 11: beat is accepted and dropped; `err_mode` is set.
- **FSM states:** IDLE, ACC, DONE.
  - IDLE + beat: `acc_k` ← decoded lane k; latch `out_mode` ← `mode`; `out_count` ← 1; go to ACC, or to DONE if `last`.
  - ACC + beat, `mode == out_mode`: `acc_k` += lane k, wrapping mod 2^`ACC_W`; `out_count` increments, saturating at all-ones; go to DONE if `last`.
  - ACC + beat, mode differs (or 11): beat is dropped (no accumulate, no count); `err_mode` ← 1; `last` still closes the group (go to DONE).
  - DONE: `out_valid=1`. On `out_ready`, go to IDLE, unless a beat is accepted in the same cycle. In that case the beat is treated as an IDLE beat and starts a fresh group (no add to old sums).
- **`in_ready`** = (state != DONE) | `out_ready`.
- **Output stability.** `acc_*`, `out_mode` and `out_count` hold stable while `out_valid & ~out_ready`.
- **`err_mode`** clears only on reset.

## Timing
- **Reset values:** state IDLE; `in_ready=1`; `out_valid=0`; `acc_0..3=0`; `out_mode=00`; `out_count=0`; `err_mode=0`.
- **Latency.** The beat with `last` accepted at edge t gives `out_valid=1` after edge t (1 cycle). Throughput is 1 beat/cycle, including back-to-back groups when `out_ready=1`.
- **Reset mid-group.** Partial sums are discarded. Reset has priority over any simultaneous handshake.
- A single-beat group (`last` on the first beat) is legal and gives `out_count=1`.

## Test plan
- **Mode 00, unsigned.** `result_0=0x0000FFFF`, `result_1=0x00000001`, carry 0, `last=1` -> next cycle `out_valid=1`, `acc_0=0x10000`, `acc_1..3=0`, `out_count=1`.
- **Mode 01, signed, 2 beats.** Each beat: `result_0=0`, `result_1=0x0000FFFF`, carry `4'b0010` (lane0 T=-1) -> `acc_0` = -2 (all ones except LSB), `acc_1=0`, `out_count=2`.
- **Mode 10, unsigned, 3 beats.** Each beat: `result_0=result_1=0x01010101`, carry `4'b0001` -> `acc_0=0x306`, `acc_1=acc_2=acc_3=6`, `out_count=3`.
- **Backpressure.** Hold `out_ready=0` for 5 cycles in DONE with `in_valid=1` -> `in_ready=0` and outputs unchanged. Then raise `out_ready` with a new mode-00 beat -> the beat is accepted in that same cycle, and the next result equals that beat alone.
- **Mode mismatch.** Beat 1 in mode 01 (lane0=5). Beat 2 in mode 10 with `last` -> beat 2 dropped, `acc_0=5`, `out_count=1`, `err_mode=1`, which persists through later groups until reset.
- **Reset mid-group.** Accept 2 beats, drive `reset=0` for one cycle -> all outputs return to reset values. A following 1-beat group gives only that beat's sums.
